// File: rtl/masked_hpc3_mul_bank_pipe.sv
// Bank of HPC3 masked GF(2^BIT_WIDTH) multipliers sharing operand b and the joint randomness,
// with a one-deep output stage, valid/ready handshake, randomness gating and saturating counters.
module masked_hpc3_mul_bank_pipe #(
  parameter int NUM_SHARES   = 2,
  parameter int BIT_WIDTH    = 4,
  parameter int NUM_CHANNELS = 2,
  parameter int CNT_WIDTH    = 16,
  localparam int NUM_QUAD    = NUM_SHARES * (NUM_SHARES - 1) / 2,
  localparam int NUM_RANDOM  = NUM_QUAD * BIT_WIDTH * (1 + NUM_CHANNELS)
) (
  input  logic                                          in_clock,
  input  logic                                          in_reset,
  input  logic [NUM_CHANNELS*NUM_SHARES*BIT_WIDTH-1:0]  in_a,
  input  logic [NUM_SHARES*BIT_WIDTH-1:0]               in_b,
  input  logic [NUM_RANDOM-1:0]                         in_random,
  input  logic                                          in_random_valid,
  input  logic                                          in_valid,
  output logic                                          out_ready,
  output logic [NUM_CHANNELS*NUM_SHARES*BIT_WIDTH-1:0]  out_c,
  output logic                                          out_valid,
  input  logic                                          in_ready,
  output logic [CNT_WIDTH-1:0]                          out_count,
  output logic [CNT_WIDTH-1:0]                          out_starve_count
);

  localparam int RW = NUM_QUAD * BIT_WIDTH;
  localparam logic [7:0] POLY_FULL = (BIT_WIDTH == 8) ? 8'h1B : 8'h03;
  localparam logic [BIT_WIDTH-1:0] POLY = POLY_FULL[BIT_WIDTH-1:0];

  function automatic logic [BIT_WIDTH-1:0] gfMul(input logic [BIT_WIDTH-1:0] x,
                                                 input logic [BIT_WIDTH-1:0] y);
    logic [BIT_WIDTH-1:0] acc;
    logic [BIT_WIDTH-1:0] sh;
    acc = '0;
    sh  = x;
    for (int n = 0; n < BIT_WIDTH; n++) begin
      if (y[n]) acc = acc ^ sh;
      sh = sh[BIT_WIDTH-1] ? ((sh << 1) ^ POLY) : (sh << 1);
    end
    return acc;
  endfunction

  // Index of the unordered share pair {i,j} inside a NUM_QUAD-wide randomness group.
  function automatic int quadIdx(input int i, input int j);
    int lo;
    int hi;
    lo = (i < j) ? i : j;
    hi = (i < j) ? j : i;
    return lo * NUM_SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
  endfunction

  logic [BIT_WIDTH-1:0] uQ [NUM_CHANNELS][NUM_SHARES][NUM_SHARES];
  logic [BIT_WIDTH-1:0] uD [NUM_CHANNELS][NUM_SHARES][NUM_SHARES];
  logic [BIT_WIDTH-1:0] vQ [NUM_CHANNELS][NUM_SHARES][NUM_SHARES];
  logic [BIT_WIDTH-1:0] vD [NUM_CHANNELS][NUM_SHARES][NUM_SHARES];
  logic                 validQ, validD;
  logic [CNT_WIDTH-1:0] countQ, countD, starveQ, starveD;
  logic                 accept;

  assign out_ready = !validQ || in_ready;
  assign accept    = in_valid && in_random_valid && out_ready;

  // Diagonal slot holds a_i*b_i; off-diagonal u/v pairs mask a_i*b_j so their sum cancels r and p.
  always_comb begin
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      for (int i = 0; i < NUM_SHARES; i++) begin
        for (int j = 0; j < NUM_SHARES; j++) begin
          uD[k][i][j] = '0;
          vD[k][i][j] = '0;
          if (i == j) begin
            uD[k][i][j] = gfMul(in_a[(k*NUM_SHARES+i)*BIT_WIDTH +: BIT_WIDTH],
                                in_b[i*BIT_WIDTH +: BIT_WIDTH]);
          end else begin
            uD[k][i][j] = gfMul(in_a[(k*NUM_SHARES+i)*BIT_WIDTH +: BIT_WIDTH],
                                in_b[j*BIT_WIDTH +: BIT_WIDTH] ^
                                in_random[quadIdx(i, j)*BIT_WIDTH +: BIT_WIDTH]) ^
                          in_random[RW*(1+k) + quadIdx(i, j)*BIT_WIDTH +: BIT_WIDTH];
            vD[k][i][j] = gfMul(in_a[(k*NUM_SHARES+i)*BIT_WIDTH +: BIT_WIDTH],
                                in_random[quadIdx(i, j)*BIT_WIDTH +: BIT_WIDTH]) ^
                          in_random[RW*(1+k) + quadIdx(i, j)*BIT_WIDTH +: BIT_WIDTH];
          end
        end
      end
    end
  end

  always_comb begin
    validD  = validQ;
    countD  = countQ;
    starveD = starveQ;
    if (accept) validD = 1'b1;
    else if (in_ready) validD = 1'b0;
    if (validQ && in_ready && (countQ != {CNT_WIDTH{1'b1}})) countD = countQ + 1'b1;
    if (in_valid && !in_random_valid && (starveQ != {CNT_WIDTH{1'b1}})) starveD = starveQ + 1'b1;
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      for (int k = 0; k < NUM_CHANNELS; k++)
        for (int i = 0; i < NUM_SHARES; i++)
          for (int j = 0; j < NUM_SHARES; j++) begin
            uQ[k][i][j] <= '0;
            vQ[k][i][j] <= '0;
          end
    end else if (accept) begin
      for (int k = 0; k < NUM_CHANNELS; k++)
        for (int i = 0; i < NUM_SHARES; i++)
          for (int j = 0; j < NUM_SHARES; j++) begin
            uQ[k][i][j] <= uD[k][i][j];
            vQ[k][i][j] <= vD[k][i][j];
          end
    end
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      validQ  <= 1'b0;
      countQ  <= '0;
      starveQ <= '0;
    end else begin
      validQ  <= validD;
      countQ  <= countD;
      starveQ <= starveD;
    end
  end

  always_comb begin
    out_c = '0;
    for (int k = 0; k < NUM_CHANNELS; k++)
      for (int i = 0; i < NUM_SHARES; i++)
        for (int j = 0; j < NUM_SHARES; j++)
          out_c[(k*NUM_SHARES+i)*BIT_WIDTH +: BIT_WIDTH] =
            out_c[(k*NUM_SHARES+i)*BIT_WIDTH +: BIT_WIDTH] ^ uQ[k][i][j] ^ vQ[k][i][j];
  end

  assign out_valid        = validQ;
  assign out_count        = countQ;
  assign out_starve_count = starveQ;

endmodule

// File: tb/tb_masked_hpc3_mul_bank_pipe.sv
// Directed bench for the masked multiplier bank: 3 shares, 4 channels, GF(16), 8-bit counters,
// with a queue of expected unmasked products filled on accept and drained on each result.
module tb_masked_hpc3_mul_bank_pipe;
  localparam int NS = 3;
  localparam int BW = 4;
  localparam int NC = 4;
  localparam int CW = 8;
  localparam int NQ = NS * (NS - 1) / 2;
  localparam int NR = NQ * BW * (1 + NC);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NC*NS*BW-1:0]   inA;
  logic [NS*BW-1:0]      inB;
  logic [NR-1:0]         inRandom;
  logic                  inRandomValid;
  logic                  inValid;
  logic                  outReady;
  logic [NC*NS*BW-1:0]   outC;
  logic                  outValid;
  logic                  inReady;
  logic [CW-1:0]         outCount;
  logic [CW-1:0]         outStarve;

  int checks = 0;
  int errors = 0;
  logic [NC*BW-1:0] sb[$];

  masked_hpc3_mul_bank_pipe #(
    .NUM_SHARES(NS), .BIT_WIDTH(BW), .NUM_CHANNELS(NC), .CNT_WIDTH(CW)
  ) dut (
    .in_clock(clk), .in_reset(rst), .in_a(inA), .in_b(inB),
    .in_random(inRandom), .in_random_valid(inRandomValid), .in_valid(inValid),
    .out_ready(outReady), .out_c(outC), .out_valid(outValid), .in_ready(inReady),
    .out_count(outCount), .out_starve_count(outStarve)
  );

  always #5 clk = ~clk;

  // Reference multiply: carry-less product, then reduce by x^4+x+1 from the top bit down.
  function automatic logic [BW-1:0] gfModel(input logic [BW-1:0] x, input logic [BW-1:0] y);
    logic [2*BW-2:0] prod;
    logic [2*BW-2:0] modulus;
    prod = '0;
    modulus = (2*BW-1)'(5'b10011);
    for (int i = 0; i < BW; i++)
      if (x[i]) prod = prod ^ ((2*BW-1)'(y) << i);
    for (int d = 2*BW-2; d >= BW; d--)
      if (prod[d]) prod = prod ^ (modulus << (d - BW));
    return prod[BW-1:0];
  endfunction

  function automatic logic [NC*BW-1:0] unmask(input logic [NC*NS*BW-1:0] c);
    logic [NC*BW-1:0] r;
    r = '0;
    for (int k = 0; k < NC; k++)
      for (int s = 0; s < NS; s++)
        r[k*BW +: BW] = r[k*BW +: BW] ^ c[(k*NS+s)*BW +: BW];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkResult(input string tag);
    logic [NC*BW-1:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s: observed result with empty scoreboard expected a queued entry", tag);
    end else begin
      exp = sb.pop_front();
      checkOutput(tag, 64'(unmask(outC)), 64'(exp));
    end
  endtask

  // Drives fresh random shares of the given unmasked values; push=1 queues the expected product.
  task automatic applyStimulus(input logic valid, input logic rv, input logic [NC*BW-1:0] aU,
                               input logic [BW-1:0] bU, input bit push);
    logic [BW-1:0]    s;
    logic [BW-1:0]    acc;
    logic [63:0]      rnd;
    logic [NC*BW-1:0] exp;
    for (int k = 0; k < NC; k++) begin
      acc = '0;
      for (int sh = 1; sh < NS; sh++) begin
        s = BW'($urandom);
        inA[(k*NS+sh)*BW +: BW] = s;
        acc = acc ^ s;
      end
      inA[(k*NS)*BW +: BW] = aU[k*BW +: BW] ^ acc;
      exp[k*BW +: BW] = gfModel(aU[k*BW +: BW], bU);
    end
    acc = '0;
    for (int sh = 1; sh < NS; sh++) begin
      s = BW'($urandom);
      inB[sh*BW +: BW] = s;
      acc = acc ^ s;
    end
    inB[BW-1:0] = bU ^ acc;
    rnd = {$urandom, $urandom};
    inRandom = rnd[NR-1:0];
    inValid = valid;
    inRandomValid = rv;
    if (push) sb.push_back(exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [NC*NS*BW-1:0] snapshot;
    logic [NC*BW-1:0]    unm;
    logic [NC*BW-1:0]    aRand;

    rst = 1'b1;
    inA = '0;
    inB = '0;
    inRandom = '0;
    inRandomValid = 1'b0;
    inValid = 1'b0;
    inReady = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) step();
    checkOutput("reset_valid", 64'(outValid), 64'd0);
    checkOutput("reset_c", 64'(outC), 64'd0);
    checkOutput("reset_ready", 64'(outReady), 64'd1);
    checkOutput("reset_count", 64'(outCount), 64'd0);
    checkOutput("reset_starve", 64'(outStarve), 64'd0);

    // Basic product with a1 = 0 and a0 = 3, b = 7.
    aRand = NC*BW'($urandom);
    applyStimulus(1'b1, 1'b1, {aRand[15:8], 4'h0, 4'h3}, 4'h7, 1'b1);
    step();
    inValid = 1'b0;
    checkOutput("basic_valid", 64'(outValid), 64'd1);
    unm = unmask(outC);
    checkOutput("basic_ch0", 64'(unm[3:0]), 64'h9);
    checkOutput("basic_ch1", 64'(unm[7:4]), 64'h0);
    checkResult("basic_model");
    step();
    checkOutput("basic_count", 64'(outCount), 64'd1);
    checkOutput("basic_drained", 64'(outValid), 64'd0);

    // Backpressure: hold a result while new operands wait.
    inReady = 1'b0;
    applyStimulus(1'b1, 1'b1, NC*BW'($urandom), BW'($urandom), 1'b1);
    step();
    checkOutput("bp_valid", 64'(outValid), 64'd1);
    checkResult("bp_held");
    snapshot = outC;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 1'b1, NC*BW'($urandom), BW'($urandom), 1'b0);
      #1;
      checkOutput("bp_ready", 64'(outReady), 64'd0);
      step();
      checkOutput("bp_stable", 64'(outC), 64'(snapshot));
      checkOutput("bp_valid_hold", 64'(outValid), 64'd1);
    end
    inReady = 1'b1;
    applyStimulus(1'b1, 1'b1, NC*BW'($urandom), BW'($urandom), 1'b1);
    #1;
    checkOutput("bp_release_ready", 64'(outReady), 64'd1);
    step();
    checkOutput("bp_release_valid", 64'(outValid), 64'd1);
    checkResult("bp_release_model");
    checkOutput("bp_count", 64'(outCount), 64'd2);

    // Starvation: three cycles without randomness, then a fresh vector.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b0, NC*BW'($urandom), BW'($urandom), 1'b0);
      step();
      checkOutput("starve_no_accept", 64'(outValid), 64'd0);
    end
    applyStimulus(1'b1, 1'b1, NC*BW'($urandom), BW'($urandom), 1'b1);
    step();
    checkOutput("starve_valid", 64'(outValid), 64'd1);
    checkResult("starve_model");
    checkOutput("starve_count", 64'(outStarve), 64'd3);
    checkOutput("starve_xfer_count", 64'(outCount), 64'd3);

    // Back-to-back streaming; out_count must saturate.
    for (int n = 0; n < 1000; n++) begin
      applyStimulus(1'b1, 1'b1, NC*BW'($urandom), BW'($urandom), 1'b1);
      step();
      checkOutput("stream_valid", 64'(outValid), 64'd1);
      checkResult("stream_model");
    end
    inValid = 1'b0;
    step();
    checkOutput("stream_saturate", 64'(outCount), 64'd255);
    checkOutput("stream_starve_hold", 64'(outStarve), 64'd3);

    // Reset while a result is pending: it must vanish immediately.
    inReady = 1'b0;
    applyStimulus(1'b1, 1'b1, NC*BW'($urandom), BW'($urandom), 1'b1);
    step();
    checkOutput("rst_pending_valid", 64'(outValid), 64'd1);
    inValid = 1'b0;
    sb.delete();
    rst = 1'b1;
    #1;
    checkOutput("rst_async_valid", 64'(outValid), 64'd0);
    checkOutput("rst_async_c", 64'(outC), 64'd0);
    checkOutput("rst_async_count", 64'(outCount), 64'd0);
    checkOutput("rst_async_starve", 64'(outStarve), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    inReady = 1'b1;
    step();
    step();
    checkOutput("rst_no_delivery", 64'(outValid), 64'd0);
    checkOutput("rst_count_after", 64'(outCount), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
